// File: rtl/fetch_pc_unit.sv
// Fetch PC stage: holds the PC, forms branch/jump targets, runs one imem
// request at a time and hands fetched words to IF/ID over valid/ready.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] shift_in,
    input  logic [31:0] branch_base,
    input  logic        branch_taken,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_valid;
    logic        r_pend;
    logic [31:0] r_pend_target;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_capture;
    logic        w_slot_free;

    // branch_taken has priority over jump_en when both pulse together
    assign w_redirect  = branch_taken | jump_en;
    assign w_target    = branch_taken ? (branch_base + shift_in)
                                      : {branch_base[31:28], jump_index, 2'b00};
    assign w_capture   = (r_state == S_REQ) && imem_ack && !w_redirect && !r_pend;
    // A redirect flushes the held instruction, so the slot counts as free
    assign w_slot_free = !r_valid || instr_ready || w_redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_valid       <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_target <= 32'h0;
        end else begin
            if (w_redirect)
                r_valid <= 1'b0;
            else if (w_capture)
                r_valid <= 1'b1;
            else if (r_valid && instr_ready)
                r_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_redirect)
                        r_pc <= w_target;
                    if (w_slot_free) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        if (w_redirect)
                            r_pc <= w_target;
                        else if (r_pend)
                            r_pc <= r_pend_target;
                        else begin
                            r_instr    <= imem_rdata;
                            r_instr_pc <= r_pc;
                            r_pc       <= r_pc + 32'd4;
                        end
                        r_pend  <= 1'b0;
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end else if (w_redirect) begin
                        // pc stays put so the outstanding address is stable
                        r_pend        <= 1'b1;
                        r_pend_target <= w_target;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;

endmodule
